ibex_qed_wb_buffer: RTL
=======================

IBEX_QED_WB_BUFFER -- requirements
Module: ibex_qed_wb_buffer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk_i input 1, rising-edge clock; rst_i input 1, synchronous active-high reset.
REQ-002 SHALL provide in_valid_i input 1: the producer offers a writeback entry.
REQ-003 SHALL provide in_ready_o output 1: the buffer can accept an entry.
REQ-004 SHALL provide in_waddr_i input 5: destination register; x16-x31 hold the duplicate copies.
REQ-005 SHALL provide in_wdata_i input 32: result data; ignored when in_is_load_i=1.
REQ-006 SHALL provide in_is_load_i input 1: the entry's data arrives later on the LSU response.
REQ-007 SHALL provide in_qed_i input 1: the entry is a QED-valid instruction.
REQ-008 SHALL provide lsu_rvalid_i input 1, lsu_rdata_i input 32 and lsu_err_i input 1: the load response.
REQ-009 SHALL provide rf_we_o output 1, rf_waddr_o output 5, rf_wdata_o output 32 and rf_qed_vld_o output 1: the register-file write port and the QED commit tag.
REQ-010 SHALL provide busy_o output 1 (at least one entry held) and load_pend_o output 1 (at least one load is waiting for data).

Function
REQ-011 SHALL be an in-order FIFO of depth 2; each entry holds waddr, data, qed, is_load and filled.
REQ-012 SHALL drive in_ready_o = (count<2), from state only, with no combinational path from the rf outputs.
REQ-013 SHALL accept an entry when in_valid_i&in_ready_o; a non-load entry is stored with filled=1, a load entry with filled=0.
REQ-014 SHALL make the head eligible to retire when it is valid and filled; at most one entry retires per cycle.
REQ-015 SHALL, on retire, drive rf_we_o=1, rf_waddr_o=head.waddr, rf_wdata_o=head.data and rf_qed_vld_o=head.qed, all combinationally from the head entry.
REQ-016 SHALL, on retire with waddr=0 or with the error flag set, pop the entry with rf_we_o=0 and rf_qed_vld_o=0.
REQ-017 SHALL, on lsu_rvalid_i, fill the oldest entry with is_load=1 and filled=0: data=lsu_rdata_i, error flag=lsu_err_i.
REQ-018 SHALL ignore lsu_rvalid_i when no load is pending, with no state change.
REQ-019 SHALL give a non-load entry a latency of one cycle from acceptance to rf_we_o, when it is at the head.
REQ-020 SHALL, without the bypass, retire a load in the cycle after its lsu_rvalid_i.
REQ-021 SHALL, when accept and retire happen in the same cycle, update count by +1-1=0 with order preserved.
REQ-022 SHALL let an entry behind an unfilled load wait and never retire out of order.
REQ-023 SHALL keep all rf outputs at 0 whenever no retire occurs.

Reset
REQ-024 SHALL, while rst_i=1 at a clock edge, clear count, all valid/filled/error flags and the pointers.
REQ-025 SHALL drive in_ready_o=1 after reset; rf_we_o, rf_qed_vld_o, busy_o and load_pend_o SHALL be 0.
REQ-026 SHALL discard any pending entries, including unfilled loads, on reset mid-operation; a later lsu_rvalid_i is then ignored per REQ-018.

Configuration
REQ-027 SHALL use macro QED_WB_LOAD_BYPASS_EN: when defined, a head entry that is an unfilled load SHALL retire in the same cycle as lsu_rvalid_i, driving lsu_rdata_i onto rf_wdata_o.
REQ-028 SHALL, when the macro is undefined, use the registered one-cycle path of REQ-020.

Verification
REQ-029 SHALL cover: reset, then accept {waddr=5, data=0xDEADBEEF, qed=1} -> next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF, rf_qed_vld_o=1.
REQ-030 SHALL cover: accept load waddr=21, then ALU waddr=3 data=7, then three cycles later rvalid data=0x55 -> in_ready_o=0 while full; waddr 21 (0x55) commits, then waddr 3 (7) on the following cycle.
REQ-031 SHALL cover: accept waddr=0 data=0x1 -> entry drains after 1 cycle, rf_we_o stays 0, busy_o returns 0.
REQ-032 SHALL cover: load with lsu_err_i=1 -> entry pops with rf_we_o=0; lsu_rvalid_i while empty -> no change.
REQ-033 SHALL cover: with the FIFO full, rst_i pulsed for one cycle -> count=0, in_ready_o=1, and a later rvalid causes no write.
REQ-034 SHALL cover: with QED_WB_LOAD_BYPASS_EN defined, a head load of waddr=18 and rvalid data=0xA5 -> rf_we_o=1 in the same cycle with rf_wdata_o=0xA5.

Source files
------------

// File: rtl/ibex_qed_wb_buffer_if.sv
// Writeback-buffer bus: producer offer/ready, LSU load response, register-file write port and status.
// Signals only, no storage, so it adds no latency.
// Backpressure is carried by in_ready_o; the rf write port and LSU response have no backpressure.
interface ibex_qed_wb_buffer_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [4:0]  in_waddr_i;
  logic [31:0] in_wdata_i;
  logic        in_is_load_i;
  logic        in_qed_i;
  logic        lsu_rvalid_i;
  logic [31:0] lsu_rdata_i;
  logic        lsu_err_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        rf_qed_vld_o;
  logic        busy_o;
  logic        load_pend_o;

  // Producer / environment side.
  modport master (
    output in_valid_i, in_waddr_i, in_wdata_i, in_is_load_i, in_qed_i,
    output lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
    input  in_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, rf_qed_vld_o,
    input  busy_o, load_pend_o
  );

  // Buffer side.
  modport slave (
    input  in_valid_i, in_waddr_i, in_wdata_i, in_is_load_i, in_qed_i,
    input  lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
    output in_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, rf_qed_vld_o,
    output busy_o, load_pend_o
  );
endinterface

// File: rtl/ibex_qed_wb_buffer.sv
// In-order 2-entry QED writeback buffer; loads wait in place for their LSU response.
// Latency: a filled head retires combinationally, one cycle after accept or after the load fill.
// Backpressure: in_ready_o = (count < 2), from state only. Optional macro QED_WB_LOAD_BYPASS_EN
// retires a head load in the same cycle as lsu_rvalid_i.
module ibex_qed_wb_buffer (
  input logic                 clk_i,
  input logic                 rst_i,
  ibex_qed_wb_buffer_if.slave bus
);

  logic        r_vld     [2];
  logic [4:0]  r_waddr   [2];
  logic [31:0] r_data    [2];
  logic        r_qed     [2];
  logic        r_is_load [2];
  logic        r_filled  [2];
  logic        r_err     [2];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_count;

  logic [1:0]  w_pend;
  logic        w_accept;
  logic        w_bypass;
  logic        w_retire;
  logic        w_ret_err;
  logic [31:0] w_ret_data;
  logic        w_drop;
  logic        w_fill_vld;
  logic        w_fill_idx;

  // A slot is waiting for load data when it is held, is a load, and has not been filled.
  assign w_pend[0] = r_vld[0] & r_is_load[0] & ~r_filled[0];
  assign w_pend[1] = r_vld[1] & r_is_load[1] & ~r_filled[1];

  assign w_accept = bus.in_valid_i & bus.in_ready_o;

`ifdef QED_WB_LOAD_BYPASS_EN
  // The head load takes its data straight from the LSU response.
  assign w_bypass = bus.lsu_rvalid_i & w_pend[r_rptr];
`else
  assign w_bypass = 1'b0;
`endif

  assign w_retire   = (r_vld[r_rptr] & r_filled[r_rptr]) | w_bypass;
  assign w_ret_err  = w_bypass ? bus.lsu_err_i   : r_err[r_rptr];
  assign w_ret_data = w_bypass ? bus.lsu_rdata_i : r_data[r_rptr];
  // x0 writes and faulted loads leave the buffer without touching the register file.
  assign w_drop     = (r_waddr[r_rptr] == 5'd0) | w_ret_err;

  // The response belongs to the oldest pending load; the head is older than the other slot.
  // A bypassed response is consumed by the retire, so it never also fills a slot.
  assign w_fill_idx = w_pend[r_rptr] ? r_rptr : ~r_rptr;
  assign w_fill_vld = bus.lsu_rvalid_i & (|w_pend) & ~w_bypass;

  assign bus.in_ready_o  = (r_count != 2'd2);
  assign bus.busy_o      = (r_count != 2'd0);
  assign bus.load_pend_o = |w_pend;

  // Register-file port is driven from the head only on retire and held at zero otherwise.
  always_comb begin
    bus.rf_we_o      = 1'b0;
    bus.rf_waddr_o   = 5'd0;
    bus.rf_wdata_o   = 32'd0;
    bus.rf_qed_vld_o = 1'b0;
    if (w_retire) begin
      bus.rf_we_o      = ~w_drop;
      bus.rf_waddr_o   = r_waddr[r_rptr];
      bus.rf_wdata_o   = w_ret_data;
      bus.rf_qed_vld_o = r_qed[r_rptr] & ~w_drop;
    end
  end

  // Slot storage, pointers and occupancy: accept at the tail, fill loads, pop the head.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        r_vld[i]    <= 1'b0;
        r_filled[i] <= 1'b0;
        r_err[i]    <= 1'b0;
      end
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_retire) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= ~r_rptr;
      end
      if (w_fill_vld) begin
        r_data[w_fill_idx]   <= bus.lsu_rdata_i;
        r_err[w_fill_idx]    <= bus.lsu_err_i;
        r_filled[w_fill_idx] <= 1'b1;
      end
      // The tail slot is always empty when accepting, so it never collides with fill or pop.
      if (w_accept) begin
        r_vld[r_wptr]     <= 1'b1;
        r_waddr[r_wptr]   <= bus.in_waddr_i;
        r_data[r_wptr]    <= bus.in_wdata_i;
        r_qed[r_wptr]     <= bus.in_qed_i;
        r_is_load[r_wptr] <= bus.in_is_load_i;
        r_filled[r_wptr]  <= ~bus.in_is_load_i;
        r_err[r_wptr]     <= 1'b0;
        r_wptr            <= ~r_wptr;
      end
      r_count <= r_count + {1'b0, w_accept} - {1'b0, w_retire};
    end
  end

endmodule
